// File: rtl/sram_arb.sv
// ============================================================================
// Module   : sram_arb
// Brief    : Single-outstanding arbiter sharing one SRAM-like port between an
//            instruction fetch requester and a data requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_starve_cnt;
  logic              r_cancel;
  logic              r_owner_data;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [STRB_W-1:0] r_wstrb;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_idle;
  logic w_inst_win;
  logic w_data_win;
  logic w_resp_done;

  // Inst wins when data is absent, or when it has been starved long enough.
  assign w_idle      = (r_state == S_IDLE);
  assign w_inst_win  = inst_req && !flush && (!data_req || (r_starve_cnt == 2'd3));
  assign w_data_win  = data_req && !w_inst_win;
  assign w_resp_done = (r_state == S_RESP) && mem_data_ok;

  // Gated by resetn so no request is accepted while reset is held.
  assign inst_addr_ok = resetn && w_idle && w_inst_win;
  assign data_addr_ok = resetn && w_idle && w_data_win;

  assign inst_data_ok = w_resp_done && !r_owner_data && !r_cancel && !flush;
  assign data_data_ok = w_resp_done && r_owner_data;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_req   = (r_state == S_REQ);
  assign mem_wr    = r_wr;
  assign mem_size  = r_size;
  assign mem_wstrb = r_wstrb;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign busy = !w_idle;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 2'd0;
      r_cancel     <= 1'b0;
      r_owner_data <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_wstrb      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cancel <= 1'b0;
          if (w_data_win) begin
            r_state      <= S_REQ;
            r_owner_data <= 1'b1;
            r_wr         <= data_wr;
            r_size       <= data_size;
            r_wstrb      <= data_wstrb;
            r_addr       <= data_addr;
            r_wdata      <= data_wdata;
            if (!inst_req)
              r_starve_cnt <= 2'd0;
            else if (r_starve_cnt != 2'd3)
              r_starve_cnt <= r_starve_cnt + 2'd1;
          end else if (w_inst_win) begin
            r_state      <= S_REQ;
            r_owner_data <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= 2'd2;
            r_wstrb      <= '0;
            r_addr       <= inst_addr;
            r_wdata      <= '0;
            r_starve_cnt <= 2'd0;
          end else if (!inst_req) begin
            r_starve_cnt <= 2'd0;
          end
        end
        S_REQ: begin
          if (flush && !r_owner_data)
            r_cancel <= 1'b1;
          if (mem_addr_ok)
            r_state <= S_RESP;
        end
        S_RESP: begin
          // Return to idle takes priority over a same-cycle flush.
          if (mem_data_ok) begin
            r_state  <= S_IDLE;
            r_cancel <= 1'b0;
          end else if (flush && !r_owner_data) begin
            r_cancel <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cancel <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
